// File: rtl/maze_pkg.sv
// Shared maze identifiers, goal FSM states and default goal tile geometry.
// Used by the goal detector and the renderer.
package maze_pkg;

   typedef enum logic [1:0] {
      MAZE_NONE,
      MAZE1,
      MAZE2,
      MAZE3
   } maze_id_t;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      DWELL,
      REACHED
   } goal_fsm_t;

   localparam int GOAL_TILE   = 16;
   localparam int DEF_GOAL1_X = 608;
   localparam int DEF_GOAL1_Y = 448;
   localparam int DEF_GOAL2_X = 16;
   localparam int DEF_GOAL2_Y = 448;
   localparam int DEF_GOAL3_X = 608;
   localparam int DEF_GOAL3_Y = 16;

endpackage

// File: rtl/goal_tile_cmp.sv
// Combinational test of whether a ball top-left lies inside a goal tile.
// One extra bit of width keeps gx+TILE-1 from wrapping at the screen edge.
module goal_tile_cmp #(
   parameter int COORD_W = 10,
   parameter int TILE    = 16
) (
   input  logic [COORD_W-1:0] ball_x,
   input  logic [COORD_W-1:0] ball_y,
   input  logic [COORD_W-1:0] gx,
   input  logic [COORD_W-1:0] gy,
   output logic               in_tile
);

   localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(TILE - 1);

   logic [COORD_W:0] bx;
   logic [COORD_W:0] by;
   logic [COORD_W:0] x_lo;
   logic [COORD_W:0] y_lo;
   logic [COORD_W:0] x_hi;
   logic [COORD_W:0] y_hi;
   logic             x_ok;
   logic             y_ok;

   assign bx   = {1'b0, ball_x};
   assign by   = {1'b0, ball_y};
   assign x_lo = {1'b0, gx};
   assign y_lo = {1'b0, gy};
   assign x_hi = x_lo + SPAN;
   assign y_hi = y_lo + SPAN;

   assign x_ok = (bx >= x_lo) && (bx <= x_hi);
   assign y_ok = (by >= y_lo) && (by <= y_hi);

   assign in_tile = x_ok && y_ok;

endmodule

// File: rtl/goal_detector.sv
// Declares a maze goal once the ball dwells in the goal tile for DWELL frames.
// The goal level is held until the control unit changes the maze select.
module goal_detector #(
   parameter int COORD_W = 10,
   parameter int TILE    = maze_pkg::GOAL_TILE,
   parameter int DWELL   = 4,
   parameter int GOAL1_X = maze_pkg::DEF_GOAL1_X,
   parameter int GOAL1_Y = maze_pkg::DEF_GOAL1_Y,
   parameter int GOAL2_X = maze_pkg::DEF_GOAL2_X,
   parameter int GOAL2_Y = maze_pkg::DEF_GOAL2_Y,
   parameter int GOAL3_X = maze_pkg::DEF_GOAL3_X,
   parameter int GOAL3_Y = maze_pkg::DEF_GOAL3_Y
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               maze1out,
   input  logic               maze2out,
   input  logic               maze3out,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] ball_x,
   input  logic [COORD_W-1:0] ball_y,
   output logic               goal_reach1,
   output logic               goal_reach2,
   output logic               goal_reach3,
   output logic [7:0]         dwell_cnt
);

   import maze_pkg::maze_id_t;
   import maze_pkg::goal_fsm_t;
   import maze_pkg::MAZE_NONE;
   import maze_pkg::MAZE1;
   import maze_pkg::MAZE2;
   import maze_pkg::MAZE3;
   import maze_pkg::IDLE;
   import maze_pkg::TRACK;
   import maze_pkg::REACHED;

   localparam logic [7:0] DWELL_C = 8'(DWELL);

   maze_id_t         sel;
   maze_id_t         active_maze;
   maze_id_t         active_nxt;
   goal_fsm_t        state;
   goal_fsm_t        state_nxt;
   logic [7:0]       cnt_nxt;
   logic [COORD_W-1:0] gx;
   logic [COORD_W-1:0] gy;
   logic             hit;
   logic             in_tile;
   logic             maze_change;
   logic             g1_nxt;
   logic             g2_nxt;
   logic             g3_nxt;

   always_comb begin
      sel = MAZE_NONE;
      case ({maze3out, maze2out, maze1out})
         3'b001:  sel = MAZE1;
         3'b010:  sel = MAZE2;
         3'b100:  sel = MAZE3;
         default: sel = MAZE_NONE;
      endcase
   end

   always_comb begin
      gx = '0;
      gy = '0;
      case (active_maze)
         MAZE1: begin
            gx = COORD_W'(GOAL1_X);
            gy = COORD_W'(GOAL1_Y);
         end
         MAZE2: begin
            gx = COORD_W'(GOAL2_X);
            gy = COORD_W'(GOAL2_Y);
         end
         MAZE3: begin
            gx = COORD_W'(GOAL3_X);
            gy = COORD_W'(GOAL3_Y);
         end
         default: ;
      endcase
   end

   goal_tile_cmp #(
      .COORD_W (COORD_W),
      .TILE    (TILE)
   ) u_cmp (
      .ball_x  (ball_x),
      .ball_y  (ball_y),
      .gx      (gx),
      .gy      (gy),
      .in_tile (hit)
   );

   assign in_tile     = hit && (active_maze != MAZE_NONE);
   assign maze_change = (sel != active_maze);

   // A select change wins over any frame_tick in the same cycle.
   always_comb begin
      state_nxt  = state;
      active_nxt = active_maze;
      cnt_nxt    = dwell_cnt;
      if (maze_change) begin
         active_nxt = sel;
         cnt_nxt    = 8'd0;
         if (sel == MAZE_NONE) state_nxt = IDLE;
         else                  state_nxt = TRACK;
      end else begin
         case (state)
            TRACK: begin
               if (frame_tick && in_tile) begin
                  cnt_nxt = 8'd1;
                  if (DWELL == 1) state_nxt = REACHED;
                  else            state_nxt = maze_pkg::DWELL;
               end
            end
            maze_pkg::DWELL: begin
               if (frame_tick) begin
                  if (in_tile) begin
                     cnt_nxt = dwell_cnt + 8'd1;
                     if (cnt_nxt == DWELL_C) state_nxt = REACHED;
                  end else begin
                     cnt_nxt   = 8'd0;
                     state_nxt = TRACK;
                  end
               end
            end
            REACHED: cnt_nxt = DWELL_C;
            default: ;
         endcase
      end
   end

   assign g1_nxt = (state_nxt == REACHED) && (active_nxt == MAZE1);
   assign g2_nxt = (state_nxt == REACHED) && (active_nxt == MAZE2);
   assign g3_nxt = (state_nxt == REACHED) && (active_nxt == MAZE3);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= IDLE;
         active_maze <= MAZE_NONE;
         dwell_cnt   <= 8'd0;
         goal_reach1 <= 1'b0;
         goal_reach2 <= 1'b0;
         goal_reach3 <= 1'b0;
      end else begin
         state       <= state_nxt;
         active_maze <= active_nxt;
         dwell_cnt   <= cnt_nxt;
         goal_reach1 <= g1_nxt;
         goal_reach2 <= g2_nxt;
         goal_reach3 <= g3_nxt;
      end
   end

endmodule

// File: doc/goal_detector.md
Name: goal_detector

Overview:
Produces the goal_reach strobes consumed by the maze-sequencing control unit. It watches the one-hot maze select (maze1out/maze2out/maze3out) and the player ball position. It declares a goal when the ball stays inside the active maze's goal tile for DWELL consecutive frames. The goal flag is held until the control unit acknowledges it by changing the maze select, so the controller's alternating Maze/Wait sampling cannot miss it.

Parameters:
COORD_W, 10, width of ball_x/ball_y (pixels)
TILE, 16, goal tile edge length in pixels
DWELL, 4, consecutive in-tile frames required; legal range 1..255
GOAL1_X / GOAL1_Y, 608 / 448, top-left pixel of maze 1 goal tile
GOAL2_X / GOAL2_Y, 16 / 448, top-left pixel of maze 2 goal tile
GOAL3_X / GOAL3_Y, 608 / 16, top-left pixel of maze 3 goal tile

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
maze1out  in  1  maze 1 selected (from control unit)
maze2out  in  1  maze 2 selected
maze3out  in  1  maze 3 selected
frame_tick  in  1  one-cycle pulse per video frame; position is sampled only on this pulse
ball_x  in  COORD_W  ball top-left x
ball_y  in  COORD_W  ball top-left y
goal_reach1  out  1  maze 1 goal reached, level, held until acknowledged
goal_reach2  out  1  maze 2 goal reached
goal_reach3  out  1  maze 3 goal reached
dwell_cnt  out  8  current consecutive in-tile frame count (debug/HUD)

Behaviour:
- Reset (Reset=0, async): state=IDLE, active_maze=NONE, dwell_cnt=0, all goal_reach*=0.
- Maze decode is combinational. If exactly one maze*out is high, sel = that maze. Otherwise sel = NONE.
- active_maze is a register. A maze change occurs on any cycle where sel != active_maze.
- In-tile test (combinational, using COORD_W+1-bit arithmetic so GX+TILE cannot wrap):
  - GX <= ball_x <= GX+TILE-1 and GY <= ball_y <= GY+TILE-1, both inclusive.
  - GX/GY are the goal coordinates of active_maze.
  - Result is 0 when active_maze=NONE.
- FSM states:
  - IDLE: outputs 0. On a maze change to sel != NONE: active_maze <= sel, dwell_cnt <= 0, go to TRACK.
  - TRACK: on a frame_tick with in_tile=1, dwell_cnt <= 1. If DWELL==1, go to REACHED; otherwise go to DWELL.
  - DWELL: on a frame_tick with in_tile=1, dwell_cnt++. When the incremented value equals DWELL, go to REACHED. On a frame_tick with in_tile=0, dwell_cnt <= 0 and go to TRACK. Cycles without frame_tick hold state.
  - REACHED: goal_reachN=1 for N=active_maze, all other goal_reach*=0. dwell_cnt saturates at DWELL. Ball movement and frame_tick are ignored.
- Maze change priority: a maze change in TRACK, DWELL or REACHED takes priority over frame_tick in the same cycle, and that tick is discarded.
  - sel = NONE: active_maze <= NONE, dwell_cnt <= 0, go to IDLE.
  - sel = new maze: active_maze <= sel, dwell_cnt <= 0, go to TRACK.
  - goal_reach* drop to 0 the cycle after the change.
- Latency: goal_reachN rises on the clock edge following the DWELL-th qualifying frame_tick. It is registered with no combinational path from the inputs.
- Only one goal_reach* may be high at any time.
- REACHED on maze 3 holds goal_reach3 indefinitely, until the select changes or reset.

Decomposition:
- Package maze_pkg:
  - maze_id_t enum {MAZE_NONE, MAZE1, MAZE2, MAZE3}
  - goal_fsm_t enum {IDLE, TRACK, DWELL, REACHED}
  - default goal coordinate and TILE constants, shared with the renderer
- Sub-module goal_tile_cmp: purely combinational in-tile comparator, parameterised by COORD_W and TILE, with inputs ball_x, ball_y, gx, gy and output in_tile. Also reusable by the renderer for goal highlighting.

Test Plan:
1. Reset low mid-DWELL (dwell_cnt=2) -> all outputs 0 within the same cycle (async); after release, state=IDLE.
2. maze1out=1, ball at (608,448), 4 frame_ticks -> dwell_cnt 1,2,3,4; goal_reach1=1 one clock after the 4th tick; goal_reach2/3 stay 0.
3. maze1out=1, ball in tile for 3 ticks, then at (624,448) (one pixel outside) on the 4th tick -> dwell_cnt=0, goal_reach1 never asserts. Edge check: (623,463) counts as in-tile.
4. In REACHED with goal_reach1=1 for 10 cycles, select switches to maze2out -> goal_reach1=0 next cycle, dwell_cnt=0, state=TRACK. Ball left at (608,448) -> no maze 2 goal.
5. maze1out and maze2out both high -> IDLE, all goal_reach*=0. Same cycle as a frame_tick with ball in tile -> tick ignored, dwell_cnt=0.
6. DWELL=1 build, maze3out=1, ball at (610,20), single frame_tick -> goal_reach3=1 next cycle and held through 1000 further ticks.
